// File: rtl/alu_control.sv
// ALU control decode for the flintRV RV32I execute stage.
// Maps {op class, funct3, funct7[5]} to a 5-bit execute code, registered once.
module alu_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] aluOp,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [4:0] aluControl
);

    typedef enum logic [3:0] {
        OP_R       = 4'd0,
        OP_I_JUMP  = 4'd1,
        OP_I_LOAD  = 4'd2,
        OP_I_ARITH = 4'd3,
        OP_I_SYS   = 4'd4,
        OP_I_FENCE = 4'd5,
        OP_S       = 4'd6,
        OP_B       = 4'd7,
        OP_U_LUI   = 4'd8,
        OP_U_AUIPC = 4'd9,
        OP_J       = 4'd10
    } op_class_t;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_PASSB = 5'd10,
        ALU_ADD4A = 5'd11,
        ALU_EQ    = 5'd12,
        ALU_NEQ   = 5'd13,
        ALU_LT    = 5'd14,
        ALU_GE    = 5'd15,
        ALU_LTU   = 5'd16,
        ALU_GEU   = 5'd17
    } alu_code_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] f3;
        logic       alt;
    } dec_key_t;

    dec_key_t  key;
    alu_code_t arith_code;
    alu_code_t next_code;

    // Only funct7[5] distinguishes instructions; the rest never reaches the decode.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign key = '{op: aluOp, f3: funct3, alt: funct7[5]};

    // Shared R / I_ARITH table; I_ARITH overrides the 000 slot below.
    always_comb begin
        arith_code = ALU_ADD;
        case (key.f3)
            3'b000: arith_code = key.alt ? ALU_SUB : ALU_ADD;
            3'b001: arith_code = ALU_SLL;
            3'b010: arith_code = ALU_SLT;
            3'b011: arith_code = ALU_SLTU;
            3'b100: arith_code = ALU_XOR;
            3'b101: arith_code = key.alt ? ALU_SRA : ALU_SRL;
            3'b110: arith_code = ALU_OR;
            3'b111: arith_code = ALU_AND;
            default: arith_code = ALU_ADD;
        endcase
    end

    always_comb begin
        next_code = ALU_ADD;
        case (op_class_t'(key.op))
            OP_R:       next_code = arith_code;
            OP_I_ARITH: next_code = (key.f3 == 3'b000) ? ALU_ADD : arith_code;
            OP_B: begin
                case (key.f3)
                    3'b000:  next_code = ALU_EQ;
                    3'b001:  next_code = ALU_NEQ;
                    3'b100:  next_code = ALU_LT;
                    3'b101:  next_code = ALU_GE;
                    3'b110:  next_code = ALU_LTU;
                    3'b111:  next_code = ALU_GEU;
                    default: next_code = ALU_ADD;
                endcase
            end
            OP_I_JUMP, OP_J: next_code = ALU_ADD4A;
            OP_U_LUI:        next_code = ALU_PASSB;
            OP_I_LOAD, OP_S, OP_U_AUIPC, OP_I_SYS, OP_I_FENCE: next_code = ALU_ADD;
            default:         next_code = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) aluControl <= ALU_ADD;
        else     aluControl <= next_code;
    end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed cases plus random sweep
// against a table-driven reference of the RV32I ALU decode.
module tb_alu_control;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [3:0] aluOp;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] aluControl;

    int n_tests = 0;
    int n_fail  = 0;

    alu_control dut (
        .clk        (clk),
        .rst        (rst),
        .aluOp      (aluOp),
        .funct7     (funct7),
        .funct3     (funct3),
        .aluControl (aluControl)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    function automatic logic [4:0] ref_code(input logic [3:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [4:0] arith[8];
        logic [4:0] br[8];
        logic [4:0] a;
        arith = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        br    = '{5'd12, 5'd13, 5'd0, 5'd0, 5'd14, 5'd15, 5'd16, 5'd17};
        // funct7[5] selects the alternate op (SUB / SRA) in the two slots that have one
        a = arith[f3] + ((f7[5] && (f3 == 3'd0 || f3 == 3'd5)) ? 5'd1 : 5'd0);
        case (op)
            4'd0:        return a;
            4'd3:        return (f3 == 3'd0) ? 5'd0 : a;
            4'd7:        return br[f3];
            4'd1, 4'd10: return 5'd11;
            4'd8:        return 5'd10;
            default:     return 5'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        n_tests++;
        assert (aluControl === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, aluControl, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, check at next negedge.
    task automatic step(input string tag, input logic [3:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
        aluOp = op; funct3 = f3; funct7 = f7;
        @(negedge clk);
        check(tag, ref_code(op, f3, f7));
    endtask

    initial begin
        logic [3:0] op;
        logic [4:0] held;
        clk_en = 1'b0;
        rst = 1'b0;
        aluOp = 4'd8; funct3 = 3'd0; funct7 = 7'd0;
        #1 rst = 1'b1;
        #2 check("reset_no_clock", 5'd0);

        clk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_held_lui", 5'd0);
        end
        rst = 1'b0;

        step("r_sub",   4'd0, 3'b000, 7'b0100000);
        step("r_sra",   4'd0, 3'b101, 7'b0100000);
        step("r_and",   4'd0, 3'b111, 7'b0000000);
        step("r_f7_b0", 4'd0, 3'b000, 7'b0000001);
        step("i_addi",  4'd3, 3'b000, 7'b0100000);
        step("i_srai",  4'd3, 3'b101, 7'b0100000);
        step("i_srli",  4'd3, 3'b101, 7'b0000000);
        foreach (funct3[i]) begin end
        for (int f = 0; f < 8; f++)
            step("b_sweep", 4'd7, 3'(f), 7'($urandom));

        // Fixed classes with random funct fields
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: op = 4'd2; 1: op = 4'd6; 2: op = 4'd9;
                3: op = 4'd1; 4: op = 4'd10; 5: op = 4'd8;
                6: op = 4'd4; 7: op = 4'd5; default: op = 4'd13;
            endcase
            step("fixed_class", op, 3'($urandom), 7'($urandom));
        end

        for (int k = 0; k < 300; k++)
            step("random", 4'($urandom), 3'($urandom), 7'($urandom));

        // Inputs changing after the edge must not disturb the registered value
        aluOp = 4'd8; funct3 = 3'd0; funct7 = 7'd0;
        @(posedge clk);
        #1 aluOp = 4'd1;
        @(negedge clk);
        check("hold_between_edges", 5'd10);

        // Async reset mid-stream, then fresh decode after release
        step("pre_reset_geu", 4'd7, 3'b111, 7'd0);
        held = aluControl;
        #1 rst = 1'b1;
        #1 check("async_reset_drop", 5'd0);
        n_tests++;
        assert (held === 5'd17)
        else begin
            n_fail++;
            $error("FAIL pre_reset_value: got %0d expected %0d", held, 5'd17);
        end
        @(negedge clk);
        check("reset_held", 5'd0);
        rst = 1'b0;
        step("post_reset_sra", 4'd0, 3'b101, 7'b0100000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
